// File: rtl/goal_seek_ctrl.sv
// goal_seek_ctrl: IR-beacon goal-seek direction controller (spin search, IR debounce, timed align, back-off, pause)
// Optional feature macro: GOAL_SEEK_WATCHDOG_EN adds a SEARCH watchdog that drives Fault; without it Fault is 0.
// Ports: clk, rst_n (async active-low); Enable, Pause, Inductance, IR_1k, IR_10k inputs;
//   FWD_A/FWD_B/BWD_A/BWD_B motion lines, Duty_SelA/Duty_SelB duty selects,
//   Done (high in IDLE), Goal_Hit (align-complete pulse), Goal_Id (0=1 kHz, 1=10 kHz), Fault (watchdog expiry).
module goal_seek_ctrl #(
    parameter int ALIGN_CYC   = 100_000_000,
    parameter int BACKOFF_CYC = 200_000_000,
    parameter int DEB_CYC     = 1000,
    parameter int SWEEP_CYC   = 0,
    parameter int DUTY_W      = 2,
    parameter int DUTY_SEARCH = 0,
    parameter int DUTY_ALIGN  = 2,
    parameter int DUTY_BACK   = 3,
    parameter int WDOG_CYC    = 1_000_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Enable,
    input  logic              Pause,
    input  logic              Inductance,
    input  logic              IR_1k,
    input  logic              IR_10k,
    output logic              FWD_A,
    output logic              FWD_B,
    output logic              BWD_A,
    output logic              BWD_B,
    output logic [DUTY_W-1:0] Duty_SelA,
    output logic [DUTY_W-1:0] Duty_SelB,
    output logic              Done,
    output logic              Goal_Hit,
    output logic              Goal_Id,
    output logic              Fault
);
    localparam int AW = $clog2(ALIGN_CYC + 1);
    localparam int BW = $clog2(BACKOFF_CYC + 1);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int SW = SWEEP_CYC > 0 ? $clog2(SWEEP_CYC + 1) : 1;
    localparam logic [AW-1:0] A_END  = AW'(ALIGN_CYC - 1);
    localparam logic [BW-1:0] B_END  = BW'(BACKOFF_CYC - 1);
    localparam logic [DW-1:0] DB_END = DW'(DEB_CYC - 1);
    localparam logic [SW-1:0] S_END  = SW'(SWEEP_CYC > 0 ? SWEEP_CYC - 1 : 0);
    localparam logic [DUTY_W-1:0] D_SRCH = DUTY_W'(DUTY_SEARCH);
    localparam logic [DUTY_W-1:0] D_ALGN = DUTY_W'(DUTY_ALIGN);
    localparam logic [DUTY_W-1:0] D_BACK = DUTY_W'(DUTY_BACK);

    typedef enum logic [2:0] {IDLE, SEARCH, ALIGN_R, ALIGN_L, BACKOFF, PAUSE} state_t;

    state_t            r_state, r_ret, r_pret, w_next;
    logic [AW-1:0]     r_tmr;
    logic [BW-1:0]     r_bo;
    logic [DW-1:0]     r_d1, r_d10;
    logic [SW-1:0]     r_sw;
    logic              r_dir;
    logic [3:0]        r_mot;
    logic [DUTY_W-1:0] r_duty;
    logic              r_done, r_hit, r_id;
    logic              w_goal, w_stay_s, w_wrap, w_dir, w_wdog, w_fault;

`ifdef GOAL_SEEK_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0] W_END = WW'(WDOG_CYC - 1);
    logic [WW-1:0] r_wd;
    logic          r_fault;
    assign w_wdog  = r_wd == W_END;
    assign w_fault = r_fault;
`else
    assign w_wdog  = 1'b0;
    assign w_fault = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_goal = 1'b0;
        case (r_state)
            IDLE: w_next = Enable && !w_fault ? SEARCH : IDLE;
            SEARCH: begin
                if (!Enable) w_next = IDLE;
                else if (Pause) w_next = PAUSE;
                else if (Inductance) w_next = BACKOFF;
                else if (w_wdog) w_next = IDLE;
                else if (IR_1k && r_d1 == DB_END) w_next = ALIGN_R;
                else if (IR_10k && r_d10 == DB_END) w_next = ALIGN_L;
            end
            ALIGN_R, ALIGN_L: begin
                if (!Enable) w_next = IDLE;
                else if (Pause) w_next = PAUSE;
                else if (Inductance) w_next = BACKOFF;
                else if (r_tmr == A_END) begin
                    w_next = IDLE;
                    w_goal = 1'b1;
                end
            end
            BACKOFF: begin
                if (!Enable) w_next = IDLE;
                else if (Pause) w_next = PAUSE;
                else if (r_bo == B_END && !Inductance) w_next = r_ret;
            end
            PAUSE: begin
                if (!Enable) w_next = IDLE;
                else if (!Pause) w_next = r_pret;
            end
            default: w_next = IDLE;
        endcase
    end

    // Debounce and sweep only advance on edges that keep the FSM in SEARCH
    assign w_stay_s = r_state == SEARCH && w_next == SEARCH;
    assign w_wrap   = SWEEP_CYC != 0 && r_sw == S_END;
    assign w_dir    = w_next == IDLE ? 1'b0 : (w_stay_s && w_wrap) ? ~r_dir : r_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ret   <= SEARCH;
            r_pret  <= SEARCH;
            r_tmr   <= '0;
            r_bo    <= '0;
            r_d1    <= '0;
            r_d10   <= '0;
            r_sw    <= '0;
            r_dir   <= 1'b0;
            r_mot   <= 4'b0000;
            r_duty  <= '0;
            r_done  <= 1'b1;
            r_hit   <= 1'b0;
            r_id    <= 1'b0;
`ifdef GOAL_SEEK_WATCHDOG_EN
            r_wd    <= '0;
            r_fault <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            // Back-off returns to the motion state it interrupted; pause returns to whatever it interrupted
            if (w_next == BACKOFF && r_state != BACKOFF && r_state != PAUSE) r_ret <= r_state;
            if (w_next == PAUSE && r_state != PAUSE) r_pret <= r_state;
            // Align timer counts completed align cycles and is held through back-off and pause
            r_tmr <= w_next == IDLE ? '0
                   : (w_next == r_state && (r_state == ALIGN_R || r_state == ALIGN_L)) ? r_tmr + 1'b1 : r_tmr;
            // Back-off timer saturates at its terminal value while Inductance keeps us here
            r_bo  <= (w_next != BACKOFF && w_next != PAUSE) ? '0
                   : (r_state == BACKOFF && w_next == BACKOFF && r_bo != B_END) ? r_bo + 1'b1 : r_bo;
            r_d1  <= w_stay_s && IR_1k ? r_d1 + 1'b1 : '0;
            r_d10 <= w_stay_s && IR_10k ? r_d10 + 1'b1 : '0;
            r_sw  <= w_next == IDLE ? '0 : (w_stay_s && SWEEP_CYC != 0) ? (w_wrap ? '0 : r_sw + 1'b1) : r_sw;
            r_dir <= w_dir;
            r_mot <= w_next == SEARCH ? (w_dir ? 4'b0110 : 4'b1001)
                   : w_next == ALIGN_R ? 4'b1001
                   : w_next == ALIGN_L ? 4'b0110
                   : w_next == BACKOFF ? 4'b0011 : 4'b0000;
            r_duty <= w_next == SEARCH ? D_SRCH
                    : (w_next == ALIGN_R || w_next == ALIGN_L) ? D_ALGN
                    : w_next == BACKOFF ? D_BACK : '0;
            r_done <= w_next == IDLE;
            r_hit  <= w_goal;
            if (w_goal) r_id <= r_state == ALIGN_L;
`ifdef GOAL_SEEK_WATCHDOG_EN
            r_wd    <= w_next == IDLE ? '0 : w_stay_s ? r_wd + 1'b1 : r_wd;
            r_fault <= !Enable ? 1'b0 : (r_state == SEARCH && w_wdog && w_next == IDLE) ? 1'b1 : r_fault;
`endif
        end
    end

    assign {FWD_A, FWD_B, BWD_A, BWD_B} = r_mot;
    assign Duty_SelA = r_duty;
    assign Duty_SelB = r_duty;
    assign Done      = r_done;
    assign Goal_Hit  = r_hit;
    assign Goal_Id   = r_id;
    assign Fault     = w_fault;
endmodule
